snitch_wrr_scheduler: RTL
=========================

SNITCH_WRR_SCHEDULER -- requirements
Module: snitch_wrr_scheduler

Interface
REQ-001: Parameter NrPorts, default 4, number of requester ports (2..16).
REQ-002: Parameter RespDepth, default 8, depth of the response-routing order FIFO.
REQ-003: Parameter MaxOutstanding, default 4, maximum in-flight requests per port.
REQ-004: Parameter WeightWidth, default 4, width of each per-port burst weight.
REQ-005: Parameter req_t, default snitch_pkg::dreq_t, request payload type.
REQ-006: Parameter resp_t, default snitch_pkg::dresp_t, response payload type.
REQ-007: Port list SHALL be: clk_i in 1 clock; rst_i in 1 reset; weight_i in NrPorts*WeightWidth per-port burst weights; req_payload_i in NrPorts x req_t; req_valid_i in NrPorts; req_ready_o out NrPorts; resp_payload_o out NrPorts x resp_t; resp_valid_o out NrPorts; resp_ready_i in NrPorts; req_payload_o out req_t; req_valid_o out 1; req_ready_i in 1; resp_payload_i in resp_t; resp_valid_i in 1; resp_ready_o out 1; outstanding_o out NrPorts x $clog2(MaxOutstanding+1) per-port in-flight count.
REQ-008: The block SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.

Function
REQ-009: FSM states SHALL be IDLE and BURST; owner index, quota counter, and round-robin pointer rr are registers.
REQ-010: Port i is eligible when req_valid_i[i]=1, outstanding[i] < MaxOutstanding, and the order FIFO is not full.
REQ-011: In IDLE, the first eligible port at or after rr (wrapping modulo NrPorts) SHALL be latched as owner, with quota = weight_i[owner] (weight 0 treated as 1); next state BURST. No downstream request is issued in IDLE, so first-request latency is 1 cycle.
REQ-012: In BURST: req_valid_o = eligible(owner); req_payload_o = req_payload_i[owner]; req_ready_o[owner] = req_ready_i & eligible(owner); all other req_ready_o SHALL be 0.
REQ-013: On a downstream handshake, the block SHALL decrement quota, increment outstanding[owner], and push owner into the order FIFO.
REQ-014: BURST -> IDLE with rr = (owner+1) mod NrPorts when quota reaches 0 on a handshake, or in any cycle the owner is not eligible; no handshake occurs in that exit cycle.
REQ-015: weight_i SHALL be sampled only at grant; changes mid-burst take effect at the next grant.
REQ-016: req_valid_o, once asserted, SHALL hold with a stable payload until handshake, unless the owner deasserts valid (requester protocol violation; the block does not guard it).
REQ-017: Responses are in order, one per request. While the FIFO is non-empty with head h: resp_valid_o[h] = resp_valid_i; resp_ready_o = resp_ready_i[h]; all other resp_valid_o = 0; resp_payload_o[i] = resp_payload_i for all i.
REQ-018: With the FIFO empty, resp_ready_o = 0 and all resp_valid_o = 0.
REQ-019: A response handshake SHALL pop the FIFO and decrement outstanding[h].
REQ-020: Simultaneous increment and decrement of the same port's counter SHALL leave it unchanged; simultaneous push and pop on a full FIFO SHALL be accepted only as a pop, because the full state already blocks the request.
REQ-021: outstanding_o SHALL reflect the registered counters.

Reset
REQ-022: While rst_i=1 at a clk_i edge: state = IDLE, rr = 0, quota = 0, owner = 0, all outstanding = 0, FIFO empty.
REQ-023: During and after reset: req_valid_o = 0, all req_ready_o = 0, all resp_valid_o = 0, resp_ready_o = 0.
REQ-024: Reset asserted mid-burst SHALL discard in-flight bookkeeping; responses arriving afterwards see an empty FIFO and are stalled.

Verification
REQ-025: NrPorts=4, weights all 2, all ports valid continuously, req_ready_i=1, immediate responses -> grant order 0,0,1,1,2,2,3,3,0,... with one idle cycle between bursts.
REQ-026: Port 1 only valid, weight 3, req_ready_i=1, resp_valid_i=0 -> exactly MaxOutstanding=4 requests issued, then req_ready_o[1]=0 and outstanding_o[1]=4; one response -> one more request issued.
REQ-027: Requests from ports 2,0,3 issued in that order; three responses returned -> resp_valid_o pulses on ports 2,0,3 in order; outstanding_o returns to 0.
REQ-028: RespDepth=2, responses withheld -> after 2 requests req_valid_o=0 for all ports until a response pops the FIFO.
REQ-029: weight_i[0] changed from 4 to 1 in the second cycle of port 0's burst -> the current burst still issues 4 requests; the next port-0 burst issues 1.
REQ-030: rst_i asserted for one cycle with 3 requests outstanding -> next cycle all outstanding_o=0, FIFO empty, resp_ready_o=0; arbitration restarts from port 0.

Source files
------------

// File: rtl/snitch_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snitch_wrr_scheduler
// Description : Weighted round-robin request scheduler. NrPorts requesters
//               share one downstream request channel. A granted port keeps
//               the channel for a burst of weight_i[port] requests (weight 0
//               counts as 1). Responses come back in order and are routed to
//               their requesters through an order FIFO of port indices.
//
// Ports       : clk_i, rst_i        clock, synchronous active-high reset
//               weight_i            per-port burst weights, sampled at grant
//               req_*_i / req_*_o   upstream request channels (NrPorts)
//               resp_*_o / resp_*_i upstream response channels (NrPorts)
//               req_payload_o, req_valid_o, req_ready_i    downstream request
//               resp_payload_i, resp_valid_i, resp_ready_o downstream response
//               outstanding_o       registered per-port in-flight counters
//
// Revision    : 1.0 - initial release
// ============================================================================

package snitch_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        logic [3:0]  strb;
    } dreq_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } dresp_t;
endpackage

module snitch_wrr_scheduler #(
    parameter int  NrPorts        = 4,
    parameter int  RespDepth      = 8,
    parameter int  MaxOutstanding = 4,
    parameter int  WeightWidth    = 4,
    parameter type req_t          = snitch_pkg::dreq_t,
    parameter type resp_t         = snitch_pkg::dresp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrPorts*WeightWidth-1:0]      weight_i,
    input  req_t                                req_payload_i [NrPorts],
    input  logic [NrPorts-1:0]                  req_valid_i,
    output logic [NrPorts-1:0]                  req_ready_o,
    output resp_t                               resp_payload_o [NrPorts],
    output logic [NrPorts-1:0]                  resp_valid_o,
    input  logic [NrPorts-1:0]                  resp_ready_i,
    output req_t                                req_payload_o,
    output logic                                req_valid_o,
    input  logic                                req_ready_i,
    input  resp_t                               resp_payload_i,
    input  logic                                resp_valid_i,
    output logic                                resp_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o [NrPorts]
);

    localparam int c_IDX_W  = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int c_CNT_W  = $clog2(MaxOutstanding + 1);
    localparam int c_PTR_W  = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int c_FILL_W = $clog2(RespDepth + 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [c_IDX_W-1:0]     r_owner;
    logic [WeightWidth-1:0] r_quota;
    logic [c_IDX_W-1:0]     r_rr;
    logic [c_CNT_W-1:0]     r_outstanding [NrPorts];
    logic [c_IDX_W-1:0]     r_fifo [RespDepth];
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [c_FILL_W-1:0]    r_fill;

    // ------------------------------------------------------------------------
    // Eligibility and grant search
    // ------------------------------------------------------------------------
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_IDX_W-1:0]     w_head;
    logic [NrPorts-1:0]     w_eligible;
    logic                   w_owner_elig;
    logic [WeightWidth-1:0] w_weight [NrPorts];
    logic                   w_grant_found;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic [WeightWidth-1:0] w_grant_quota;
    logic [c_IDX_W-1:0]     w_next_rr;
    int                     w_scan;

    assign w_fifo_full  = (r_fill == c_FILL_W'(RespDepth));
    assign w_fifo_empty = (r_fill == '0);
    assign w_head       = r_fifo[r_head];

    // A full order FIFO blocks every port, so a push can never meet a full
    // FIFO even when a pop happens in the same cycle.
    generate
        for (genvar i = 0; i < NrPorts; i++) begin : g_port
            assign w_eligible[i] = req_valid_i[i]
                                && (r_outstanding[i] < c_CNT_W'(MaxOutstanding))
                                && !w_fifo_full;
            assign w_weight[i]   = weight_i[i*WeightWidth +: WeightWidth];
        end
    endgenerate

    assign w_owner_elig = w_eligible[r_owner];

    // First eligible port at or after the round-robin pointer.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = 0;
        for (int k = 0; k < NrPorts; k++) begin
            w_scan = (int'(r_rr) + k) % NrPorts;
            if (!w_grant_found && w_eligible[w_scan[c_IDX_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[c_IDX_W-1:0];
            end
        end
    end

    assign w_grant_quota = (w_weight[w_grant_idx] == '0) ? WeightWidth'(1)
                                                          : w_weight[w_grant_idx];
    assign w_next_rr     = (r_owner == c_IDX_W'(NrPorts - 1)) ? '0
                                                              : r_owner + 1'b1;

    // ------------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------------
    logic w_burst;
    logic w_req_hs;
    logic w_push;

    // Outputs are forced quiet while reset is asserted, not only after it.
    assign w_burst       = (r_state == c_BURST) && !rst_i;
    assign req_valid_o   = w_burst && w_owner_elig;
    assign req_payload_o = req_payload_i[r_owner];
    assign w_req_hs      = req_valid_o && req_ready_i;
    assign w_push        = w_req_hs && !w_fifo_full;

    always_comb begin
        req_ready_o = '0;
        if (w_burst && w_owner_elig) begin
            req_ready_o[r_owner] = req_ready_i;
        end
    end

    // ------------------------------------------------------------------------
    // Response channel
    // ------------------------------------------------------------------------
    logic w_resp_active;
    logic w_pop;

    assign w_resp_active = !w_fifo_empty && !rst_i;
    assign resp_ready_o  = w_resp_active && resp_ready_i[w_head];
    assign w_pop         = resp_valid_i && resp_ready_o;

    always_comb begin
        resp_valid_o = '0;
        if (w_resp_active) begin
            resp_valid_o[w_head] = resp_valid_i;
        end
    end

    generate
        for (genvar i = 0; i < NrPorts; i++) begin : g_resp
            assign resp_payload_o[i] = resp_payload_i;
            assign outstanding_o[i]  = r_outstanding[i];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_owner <= '0;
            r_quota <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant_found) begin
                        r_owner <= w_grant_idx;
                        r_quota <= w_grant_quota;
                        r_state <= c_BURST;
                    end
                end
                c_BURST: begin
                    // An owner that stops being eligible gives up the rest of
                    // its quota so other ports are not starved.
                    if (!w_owner_elig) begin
                        r_state <= c_IDLE;
                        r_rr    <= w_next_rr;
                    end else if (w_req_hs) begin
                        r_quota <= r_quota - 1'b1;
                        if (r_quota == WeightWidth'(1)) begin
                            r_state <= c_IDLE;
                            r_rr    <= w_next_rr;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-port in-flight counters
    // ------------------------------------------------------------------------
    logic [NrPorts-1:0] w_cnt_inc;
    logic [NrPorts-1:0] w_cnt_dec;

    generate
        for (genvar i = 0; i < NrPorts; i++) begin : g_cnt
            assign w_cnt_inc[i] = w_push && (r_owner == c_IDX_W'(i));
            assign w_cnt_dec[i] = w_pop  && (w_head  == c_IDX_W'(i));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrPorts; i++) begin
                r_outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NrPorts; i++) begin
                if (w_cnt_inc[i] && !w_cnt_dec[i]) begin
                    r_outstanding[i] <= r_outstanding[i] + 1'b1;
                end else if (!w_cnt_inc[i] && w_cnt_dec[i]) begin
                    r_outstanding[i] <= r_outstanding[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response-routing order FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_tail] <= r_owner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == c_PTR_W'(RespDepth - 1)) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_PTR_W'(RespDepth - 1)) ? '0 : r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
